// File: rtl/cvtsw_int2fp.sv
// Signed integer to IEEE-754 binary float conversion with selectable rounding.
// One registered stage: the result appears the cycle after in_valid.
module cvtsw_int2fp #(
    parameter int INTn    = 32,
    parameter int NEXP    = 8,
    parameter int NSIG    = 23,
    parameter int LAST_RA = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [INTn-1:0]      w,
    input  logic [LAST_RA:0]     ra,
    output logic                 out_valid,
    output logic [NEXP+NSIG:0]   s,
    output logic                 inexact
);

    localparam int LZW  = $clog2(INTn) + 1;
    localparam int BIAS = (1 << (NEXP - 1)) - 1;

    function automatic logic [LZW-1:0] lzc(input logic [INTn-1:0] v);
        logic [LZW-1:0] n;
        logic           found;
        n     = LZW'(INTn);
        found = 1'b0;
        for (int i = INTn - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = LZW'(INTn - 1 - i);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return n;
    endfunction

    logic                 sign_s;
    logic [INTn-1:0]      mag_s;
    logic [LZW-1:0]       lz_s;
    logic [INTn-1:0]      norm_s;
    logic [NSIG-1:0]      frac_s;
    logic                 g_s;
    logic                 st_s;
    logic                 l_s;
    logic                 nonzero_s;
    logic                 inc_s;
    logic [NSIG:0]        frac_rnd_s;
    logic [NEXP-1:0]      exp_s;
    logic [NEXP+NSIG:0]   res_s;
    logic                 inexact_s;

    logic                 out_valid_r;
    logic [NEXP+NSIG:0]   s_r;
    logic                 inexact_r;

    // The most negative input negates to 2^(INTn-1), which still fits unsigned.
    assign sign_s    = w[INTn-1];
    assign mag_s     = sign_s ? (~w + INTn'(1)) : w;
    assign lz_s      = lzc(mag_s);
    assign norm_s    = mag_s << lz_s;
    assign nonzero_s = norm_s[INTn-1];
    assign frac_s    = norm_s[INTn-2 -: NSIG];
    assign g_s       = norm_s[INTn-2-NSIG];
    assign st_s      = |norm_s[INTn-3-NSIG:0];
    assign l_s       = frac_s[0];

    // Round-up decision; the lowest set attribute bit wins, none means ties-to-even.
    always_comb begin
        inc_s = 1'b0;
        if (ra[0]) begin
            inc_s = g_s & (st_s | l_s);
        end else if (ra[1]) begin
            inc_s = 1'b0;
        end else if (ra[2]) begin
            inc_s = ~sign_s & (g_s | st_s);
        end else if (ra[3]) begin
            inc_s = sign_s & (g_s | st_s);
        end else if (ra[4]) begin
            inc_s = g_s;
        end else begin
            inc_s = g_s & (st_s | l_s);
        end
    end

    // A carry out of the fraction leaves it all-zero and bumps the exponent.
    assign frac_rnd_s = {1'b0, frac_s} + {{NSIG{1'b0}}, inc_s};
    assign exp_s      = NEXP'(INTn - 1 + BIAS) - NEXP'(lz_s)
                      + {{(NEXP-1){1'b0}}, frac_rnd_s[NSIG]};

    // Zero input gives +0 and exact regardless of mode.
    always_comb begin
        res_s     = '0;
        inexact_s = 1'b0;
        if (nonzero_s) begin
            res_s     = {sign_s, exp_s, frac_rnd_s[NSIG-1:0]};
            inexact_s = g_s | st_s;
        end else begin
            res_s     = '0;
            inexact_s = 1'b0;
        end
    end

    // Result register; s/inexact hold when no new operand arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            s_r         <= '0;
            inexact_r   <= 1'b0;
        end else if (in_valid) begin
            out_valid_r <= 1'b1;
            s_r         <= res_s;
            inexact_r   <= inexact_s;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_valid = out_valid_r;
    assign s         = s_r;
    assign inexact   = inexact_r;

endmodule

// File: tb/tb_cvtsw_int2fp.sv
// Randomised and directed bench for cvtsw_int2fp against an arithmetic
// rounding model (quotient/remainder comparison against the half-ulp point).
module tb_cvtsw_int2fp;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] w;
    logic [4:0]  ra;
    logic        out_valid;
    logic [31:0] s;
    logic        inexact;

    int errors = 0;
    int checks = 0;

    logic        exp_valid;
    logic [31:0] exp_s;
    logic        exp_inx;

    cvtsw_int2fp dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .w(w), .ra(ra),
        .out_valid(out_valid), .s(s), .inexact(inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endfunction

    // Reference: round the exact magnitude to 24 significant bits by comparing
    // the discarded remainder against half a unit in the last place.
    function automatic void model(input logic [31:0] wv, input logic [4:0] rav,
                                  output logic [31:0] rs, output logic rinx);
        logic [63:0] mag, q, rem, half;
        int p, sh, mode;
        bit sgn, up;
        sgn  = wv[31];
        mag  = {32'd0, wv};
        if (sgn) mag = 64'h1_0000_0000 - mag;
        rs   = 32'd0;
        rinx = 1'b0;
        if (mag == 64'd0) return;
        mode = 0;
        for (int i = 4; i >= 0; i--) if (rav[i]) mode = i;
        p = 63;
        while (!mag[p]) p--;
        if (p <= 23) begin
            q = mag << (23 - p);
            rem = 64'd0;
            half = 64'd1;
        end else begin
            sh = p - 23;
            q = mag >> sh;
            rem = mag & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
        end
        case (mode)
            0: up = (rem > half) || (rem == half && q[0]);
            1: up = 1'b0;
            2: up = !sgn && rem != 64'd0;
            3: up = sgn && rem != 64'd0;
            4: up = rem >= half;
            default: up = 1'b0;
        endcase
        if (rem == 64'd0) up = 1'b0;
        q = q + {63'd0, up};
        if (q[24]) begin
            q = q >> 1;
            p++;
        end
        rs   = {sgn, 8'(p + 127), q[22:0]};
        rinx = (rem != 64'd0);
    endfunction

    // Expected output register fed by the model.
    always @(posedge clk or negedge rst_n) begin
        logic [31:0] ms;
        logic        mi;
        if (!rst_n) begin
            exp_valid <= 1'b0;
            exp_s     <= 32'd0;
            exp_inx   <= 1'b0;
        end else if (in_valid) begin
            model(w, ra, ms, mi);
            exp_valid <= 1'b1;
            exp_s     <= ms;
            exp_inx   <= mi;
        end else begin
            exp_valid <= 1'b0;
        end
    end

    // Compare DUT outputs with the model every cycle, away from the active edge.
    always @(negedge clk) begin
        check("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
        if (exp_valid) begin
            check("s", s, exp_s);
            check("inexact", {31'd0, inexact}, {31'd0, exp_inx});
        end
    end

    task automatic drive(input logic v, input logic [31:0] wv, input logic [4:0] rv);
        @(negedge clk);
        in_valid = v;
        w        = wv;
        ra       = rv;
    endtask

    typedef struct {
        logic [31:0] wv;
        logic [4:0]  rv;
        logic [31:0] sv;
        logic        iv;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] ms;
        logic        mi;
        logic [31:0] rw;
        logic [4:0]  rr;

        rst_n = 1'b0; in_valid = 1'b0; w = 32'd0; ra = 5'd1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_s", s, 32'd0);
        check("reset_inexact", {31'd0, inexact}, 32'd0);
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;

        for (int m = 0; m < 5; m++) begin
            vecs.push_back('{32'h0000_0001, 5'(1 << m), 32'h3F80_0000, 1'b0});
            vecs.push_back('{32'hFFFF_FFFF, 5'(1 << m), 32'hBF80_0000, 1'b0});
            vecs.push_back('{32'h4000_0000, 5'(1 << m), 32'h4E80_0000, 1'b0});
            vecs.push_back('{32'h8000_0000, 5'(1 << m), 32'hCF00_0000, 1'b0});
            vecs.push_back('{32'h0000_0000, 5'(1 << m), 32'h0000_0000, 1'b0});
        end
        vecs.push_back('{32'h7FFF_FFFF, 5'b00001, 32'h4F00_0000, 1'b1});
        vecs.push_back('{32'h7FFF_FFFF, 5'b00100, 32'h4F00_0000, 1'b1});
        vecs.push_back('{32'h7FFF_FFFF, 5'b10000, 32'h4F00_0000, 1'b1});
        vecs.push_back('{32'h7FFF_FFFF, 5'b00010, 32'h4EFF_FFFF, 1'b1});
        vecs.push_back('{32'h7FFF_FFFF, 5'b01000, 32'h4EFF_FFFF, 1'b1});
        vecs.push_back('{32'h0100_0001, 5'b00001, 32'h4B80_0000, 1'b1});
        vecs.push_back('{32'h0100_0001, 5'b00010, 32'h4B80_0000, 1'b1});
        vecs.push_back('{32'h0100_0001, 5'b01000, 32'h4B80_0000, 1'b1});
        vecs.push_back('{32'h0100_0001, 5'b00100, 32'h4B80_0001, 1'b1});
        vecs.push_back('{32'h0100_0001, 5'b10000, 32'h4B80_0001, 1'b1});
        vecs.push_back('{32'h0100_0003, 5'b00001, 32'h4B80_0002, 1'b1});
        vecs.push_back('{32'hFEFF_FFFF, 5'b01000, 32'hCB80_0001, 1'b1});
        vecs.push_back('{32'hFEFF_FFFF, 5'b00100, 32'hCB80_0000, 1'b1});
        vecs.push_back('{32'h4000_0041, 5'b00001, 32'h4E80_0001, 1'b1});
        vecs.push_back('{32'h4000_0041, 5'b00010, 32'h4E80_0000, 1'b1});
        vecs.push_back('{32'h0100_0003, 5'b00000, 32'h4B80_0002, 1'b1});
        vecs.push_back('{32'h0100_0001, 5'b10110, 32'h4B80_0000, 1'b1});

        // Pin the model to hand-computed values, then push each through the DUT.
        foreach (vecs[i]) begin
            model(vecs[i].wv, vecs[i].rv, ms, mi);
            check("model_s", ms, vecs[i].sv);
            check("model_inexact", {31'd0, mi}, {31'd0, vecs[i].iv});
            drive(1'b1, vecs[i].wv, vecs[i].rv);
        end
        drive(1'b0, 32'd0, 5'd1);

        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0: rw = $urandom;
                1: rw = $urandom >> $urandom_range(0, 31);
                2: rw = -($urandom >> $urandom_range(0, 31));
                default: rw = ($urandom >> $urandom_range(0, 31)) << $urandom_range(0, 8);
            endcase
            rr = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'(1 << $urandom_range(0, 4));
            drive($urandom_range(0, 3) != 0, rw, rr);
        end

        for (int n = 0; n < 5; n++) drive(1'b1, 32'd0, 5'(1 << n));
        drive(1'b1, 32'h7FFF_FFFF, 5'b00001);
        drive(1'b1, 32'h0100_0003, 5'b00100);

        // Asynchronous reset asserted mid-stream while in_valid is high.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_s", s, 32'd0);
        check("async_inexact", {31'd0, inexact}, 32'd0);
        check("async_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("held_s", s, 32'd0);
        check("held_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 32'h4000_0041, 5'b00001);
        drive(1'b0, 32'd0, 5'd1);
        @(posedge clk);
        #1;
        check("post_reset_valid", {31'd0, out_valid}, 32'd0);
        check("post_reset_s", s, 32'h4E80_0001);
        check("post_reset_inexact", {31'd0, inexact}, 32'd1);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cvtsw_int2fp.md
Name: cvtsw_int2fp

Overview:
- Converts a two's-complement signed integer `w` to an IEEE-754 binary floating-point value (default binary32).
- Rounding follows a one-hot rounding-attribute vector; an inexact flag is raised when the result is not exact.
- Sits in the FP unit as the signed-word→float conversion stage: one pipeline register, 1-cycle latency.

Parameters:
- INTn, 32, integer input width. Constraints: INTn > NSIG+2 and INTn-1 < 2^(NEXP-1)-1, so the result can never overflow.
- NEXP, 8, exponent field width; bias = 2^(NEXP-1)-1.
- NSIG, 23, stored fraction field width.
- LAST_RA, 4, index of the top rounding-attribute bit. Fixed encoding:
  - bit 0: roundTiesToEven
  - bit 1: roundTowardZero
  - bit 2: roundTowardPositive
  - bit 3: roundTowardNegative
  - bit 4: roundTiesToAway

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  w/ra are valid this cycle.
- w  in  INTn  signed integer operand.
- ra  in  LAST_RA+1  one-hot rounding attribute.
- out_valid  out  1  s/inexact hold a new result.
- s  out  NEXP+NSIG+1  result as {sign, exponent[NEXP-1:0], fraction[NSIG-1:0]}.
- inexact  out  1  1 when the result differs from the exact integer value.

Behaviour:
- Reset (rst_n=0, asynchronous): s=0, inexact=0, out_valid=0 immediately; held while rst_n=0. Deassertion takes effect at the next rising edge.
- Datapath: combinational from w/ra. On every rising edge with in_valid=1, the result is registered into s/inexact and out_valid becomes 1. With in_valid=0, out_valid becomes 0 and s/inexact hold their last values.
- Latency: exactly 1 cycle. No backpressure; one result per cycle is accepted.
- Sign: sign = w[INTn-1].
- Magnitude: mag = |w| as an INTn-bit unsigned value. The most negative input (1<<(INTn-1)) yields magnitude 2^(INTn-1) with no overflow.
- Zero: w=0 gives s=all zeros (+0) and inexact=0 in every mode. The result is never −0.
- Normalisation:
  - Leading-zero count lz on mag.
  - Shift left by lz so the leading 1 sits at bit INTn-1.
  - Unbiased exponent e = INTn-1-lz; biased exponent = e + bias.
- Field extraction from the normalised magnitude:
  - Fraction = the NSIG bits below the leading 1.
  - G = the next bit below the fraction.
  - St = OR of all remaining lower bits.
  - L = fraction LSB.
- Round-up increment by mode:
  - TiesToEven: G & (St | L)
  - TowardZero: 0
  - TowardPositive: ~sign & (G | St)
  - TowardNegative: sign & (G | St)
  - TiesToAway: G
- Rounding carry: add the increment to {1, fraction}. If it carries out, the fraction becomes 0 and the exponent is incremented by 1.
- inexact = G | St, independent of the rounding mode.
- Malformed ra (not one-hot): use the lowest-index set bit. If ra = 0, use roundTiesToEven.
- Outputs are never NaN, ∞ or subnormal.

Test Plan:
- Reset: assert rst_n=0 mid-stream with in_valid=1. Outputs clear asynchronously to s=0, inexact=0, out_valid=0. After release, the first result appears one edge after in_valid.
- Exact powers of two:
  - w=1 → 0x3F800000
  - w=-1 → 0xBF800000
  - w=0x40000000 → 0x4E800000
  - w=0x80000000 → 0xCF000000
  - inexact=0 in all five modes.
- w=0x7FFFFFFF, inexact=1:
  - TiesToEven / TowardPositive / TiesToAway → 0x4F000000
  - TowardZero / TowardNegative → 0x4EFFFFFF
- Ties at 2^24+1 (w=0x01000001, inexact=1):
  - TiesToEven / TowardZero / TowardNegative → 0x4B800000
  - TowardPositive / TiesToAway → 0x4B800001
- Other tie and sign cases:
  - w=0x01000003, TiesToEven → 0x4B800002 (tie with odd L rounds up).
  - w=0xFEFFFFFF (−(2^24+1)): TowardNegative → 0xCB800001; TowardPositive → 0xCB800000.
- Sticky handling: w=0x40000041 (G=1, St=1, L=0).
  - TiesToEven → 0x4E800001
  - TowardZero → 0x4E800000
  - inexact=1.
- w=0, streaming back-to-back: s=0x00000000, inexact=0. Consecutive in_valid cycles each produce one result with out_valid held high.
